// File: rtl/serial_frame_router.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_frame_router
//
// Frame-level controller for the serial link datapath. Hunts for a fixed
// header on the serial input, captures an address field and a length field,
// then qualifies (len+1) payload bits towards one of 2**ADDR_W output ports.
// A frame is: HDR (HDR_W bits) | addr (ADDR_W bits) | len (LEN_W bits) |
// payload (len+1 bits). Every field is sent MSB-first. Only cycles with
// i_clk_en high carry a bit.
//
// Ports
//   clk           in   1          clock, rising edge
//   rst           in   1          asynchronous, active-high reset
//   i_clk_en      in   1          bit strobe; i_ser_in is sampled only when high
//   i_ser_in      in   1          serial data
//   i_abort       in   1          synchronous frame abort (highest priority)
//   o_ser_out     out  1          combinational copy of i_ser_in
//   o_port_valid  out  2**ADDR_W  one-hot payload-bit qualifier per port
//   o_cur_port    out  ADDR_W     address of the current / last frame
//   o_busy        out  1          high while in ADDR, LEN and DATA
//   o_frame_done  out  1          one-cycle pulse after the last payload bit
// -----------------------------------------------------------------------------
module serial_frame_router #(
   parameter int               HDR_W  = 6,
   parameter logic [HDR_W-1:0] HDR    = 6'b110101,
   parameter int               ADDR_W = 2,
   parameter int               LEN_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_clk_en,
   input  logic                   i_ser_in,
   input  logic                   i_abort,
   output logic                   o_ser_out,
   output logic [2**ADDR_W-1:0]   o_port_valid,
   output logic [ADDR_W-1:0]      o_cur_port,
   output logic                   o_busy,
   output logic                   o_frame_done
);

   // fill only needs to reach HDR_W-1, where it saturates.
   localparam int FILL_W  = $clog2(HDR_W);
   localparam int FLD_MAX = (LEN_W > ADDR_W) ? LEN_W : ADDR_W;
   localparam int FLD_W   = $clog2(FLD_MAX + 1);

   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HDR_W - 1);
   localparam logic [FLD_W-1:0]  ADDR_LAST = FLD_W'(ADDR_W - 1);
   localparam logic [FLD_W-1:0]  LEN_LAST  = FLD_W'(LEN_W - 1);

   typedef enum logic [2:0] {
      S_HUNT = 3'd0,
      S_ADDR = 3'd1,
      S_LEN  = 3'd2,
      S_DATA = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             r_state;
   logic [HDR_W-2:0]   r_hist;       // last HDR_W-1 bits seen while hunting
   logic [FILL_W-1:0]  r_fill;       // bits taken since entering HUNT (saturating)
   logic [ADDR_W-1:0]  r_addr;
   logic [LEN_W-1:0]   r_cnt;        // remaining payload bits minus one
   logic [FLD_W-1:0]   r_fld_cnt;    // bit index inside ADDR / LEN fields
   logic               r_busy;
   logic               r_frame_done;

   // The candidate header is the stored history plus the bit on the wire now,
   // so a match is recognised on the very bit that completes it.
   logic [HDR_W-1:0]   w_window;
   logic               w_hdr_hit;
   logic [ADDR_W:0]    w_addr_shift;
   logic [LEN_W:0]     w_cnt_shift;

   assign w_window     = {r_hist, i_ser_in};
   assign w_hdr_hit    = (r_fill >= FILL_FULL) && (w_window == HDR);
   assign w_addr_shift = {r_addr, i_ser_in};
   assign w_cnt_shift  = {r_cnt, i_ser_in};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_HUNT;
         r_hist       <= '0;
         r_fill       <= '0;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_fld_cnt    <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (i_abort) begin
         // Abort wins over the bit strobe and over every transition.
         r_state      <= S_HUNT;
         r_hist       <= '0;
         r_fill       <= '0;
         r_fld_cnt    <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         case (r_state)
            S_HUNT: begin
               if (i_clk_en) begin
                  if (w_hdr_hit) begin
                     r_state   <= S_ADDR;
                     r_busy    <= 1'b1;
                     r_fld_cnt <= '0;
                     // Leave the hunter clean for the next time HUNT is entered.
                     r_hist    <= '0;
                     r_fill    <= '0;
                  end else begin
                     r_hist <= w_window[HDR_W-2:0];
                     if (r_fill != FILL_FULL) begin
                        r_fill <= r_fill + 1'b1;
                     end
                  end
               end
            end

            S_ADDR: begin
               if (i_clk_en) begin
                  r_addr <= w_addr_shift[ADDR_W-1:0];
                  if (r_fld_cnt == ADDR_LAST) begin
                     r_state   <= S_LEN;
                     r_fld_cnt <= '0;
                  end else begin
                     r_fld_cnt <= r_fld_cnt + 1'b1;
                  end
               end
            end

            S_LEN: begin
               if (i_clk_en) begin
                  r_cnt <= w_cnt_shift[LEN_W-1:0];
                  if (r_fld_cnt == LEN_LAST) begin
                     r_state   <= S_DATA;
                     r_fld_cnt <= '0;
                  end else begin
                     r_fld_cnt <= r_fld_cnt + 1'b1;
                  end
               end
            end

            S_DATA: begin
               if (i_clk_en) begin
                  // cnt==0 marks the last bit, so cnt never wraps below zero.
                  if (r_cnt == '0) begin
                     r_state      <= S_DONE;
                     r_busy       <= 1'b0;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end

            S_DONE: begin
               // One clk cycle only, whether or not a bit strobe is present.
               r_state      <= S_HUNT;
               r_frame_done <= 1'b0;
            end

            default: begin
               r_state      <= S_HUNT;
               r_hist       <= '0;
               r_fill       <= '0;
               r_fld_cnt    <= '0;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: every output of this always_comb gets a default first, so no
   // latch is inferred for the ports that are not selected.
   always_comb begin
      o_port_valid = '0;
      if ((r_state == S_DATA) && i_clk_en) begin
         o_port_valid[r_addr] = 1'b1;
      end
   end

   assign o_ser_out    = i_ser_in;
   assign o_cur_port   = r_addr;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;

endmodule
